// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and helpers for the keypad scan controller
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DEBOUNCE,
        ST_REPORT,
        ST_RELEASE
    } scan_state_e;

    // Wide enough for any keypad up to 16 rows.
    localparam int ROW_IDX_W = 4;
    typedef logic [ROW_IDX_W-1:0] row_idx_t;

    function automatic int key_width(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchroniser with rising-edge pulse output
module sync_edge_det #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad row scanner with debounce and key handshake
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int DEBOUNCE_TICKS = 8,
    parameter int KEY_W          = key_width(ROWS, COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             div_q,
    output logic             div_ena,
    output logic [ROWS-1:0]  row_n,
    input  logic [COLS-1:0]  col_n,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_code,
    input  logic             key_ready,
    output logic             key_held,
    output logic             key_lost
);

    logic            tick;
    logic            div_level_unused;
    logic [COLS-1:0] col_s;
    logic [COLS-1:0] col_rise_unused;

    sync_edge_det #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_div_sync (
        .clk     (clk),
        .rst     (rst),
        .d_i     (div_q),
        .level_o (div_level_unused),
        .rise_o  (tick)
    );

    // Columns idle high, so reset the chain to all ones to avoid a phantom press.
    sync_edge_det #(
        .WIDTH     (COLS),
        .RESET_VAL ({COLS{1'b1}})
    ) u_col_sync (
        .clk     (clk),
        .rst     (rst),
        .d_i     (col_n),
        .level_o (col_s),
        .rise_o  (col_rise_unused)
    );

    scan_state_e      state_q;
    row_idx_t         row_q;
    logic [COLS-1:0]  col_oh_q;
    logic [7:0]       cnt_q;
    logic [ROWS-1:0]  row_n_q;
    logic             div_ena_q;
    logic             key_valid_q;
    logic [KEY_W-1:0] key_code_q;
    logic             key_held_q;
    logic             key_lost_q;

    logic [COLS-1:0]  col_low;
    logic             col_single;
    logic             col_idle;
    logic             col_match;
    row_idx_t         row_next;
    logic [ROWS-1:0]  row_n_next;
    logic [7:0]       cnt_inc;
    logic             cnt_done;
    logic [KEY_W-1:0] col_idx;
    logic [KEY_W-1:0] code_d;

    assign col_low    = ~col_s;
    assign col_single = $onehot(col_low);
    assign col_idle   = (col_low == '0);
    assign col_match  = (col_low == col_oh_q);
    assign row_next   = (row_q == row_idx_t'(ROWS - 1)) ? '0 : row_q + row_idx_t'(1);
    assign row_n_next = ~(ROWS'(1) << row_next);
    assign cnt_inc    = cnt_q + 8'd1;
    assign cnt_done   = (cnt_inc == 8'(DEBOUNCE_TICKS));

    always_comb begin
        col_idx = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col_oh_q[c]) begin
                col_idx = KEY_W'(c);
            end
        end
    end

    assign code_d = KEY_W'(row_q) * KEY_W'(COLS) + col_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_oh_q    <= '0;
            cnt_q       <= '0;
            row_n_q     <= '1;
            div_ena_q   <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
            key_lost_q  <= 1'b0;
        end else begin
            key_lost_q <= 1'b0;
            // Consumer handshake; REPORT below may re-set valid in the same cycle.
            if (key_valid_q && key_ready) begin
                key_valid_q <= 1'b0;
            end

            if (!enable) begin
                state_q    <= ST_IDLE;
                row_q      <= '0;
                row_n_q    <= '1;
                div_ena_q  <= 1'b0;
                cnt_q      <= '0;
                key_held_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q   <= ST_SCAN;
                        row_q     <= '0;
                        row_n_q   <= ~ROWS'(1);
                        div_ena_q <= 1'b1;
                        cnt_q     <= '0;
                    end
                    ST_SCAN: begin
                        if (tick) begin
                            if (col_single) begin
                                col_oh_q   <= col_low;
                                cnt_q      <= '0;
                                key_held_q <= 1'b1;
                                state_q    <= ST_DEBOUNCE;
                            end else begin
                                row_q   <= row_next;
                                row_n_q <= row_n_next;
                            end
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (tick) begin
                            if (col_match) begin
                                cnt_q <= cnt_inc;
                                if (cnt_done) begin
                                    state_q <= ST_REPORT;
                                end
                            end else begin
                                // Row stays put so the same row is re-sampled next tick.
                                cnt_q      <= '0;
                                key_held_q <= 1'b0;
                                state_q    <= ST_SCAN;
                            end
                        end
                    end
                    ST_REPORT: begin
                        if (!key_valid_q || key_ready) begin
                            key_code_q  <= code_d;
                            key_valid_q <= 1'b1;
                        end else begin
                            key_lost_q <= 1'b1;
                        end
                        cnt_q   <= '0;
                        state_q <= ST_RELEASE;
                    end
                    ST_RELEASE: begin
                        if (tick) begin
                            if (!col_idle) begin
                                cnt_q <= '0;
                            end else if (cnt_done) begin
                                cnt_q      <= '0;
                                key_held_q <= 1'b0;
                                row_q      <= row_next;
                                row_n_q    <= row_n_next;
                                state_q    <= ST_SCAN;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign div_ena   = div_ena_q;
    assign row_n     = row_n_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;
    assign key_lost  = key_lost_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - self-checking bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DB    = 4;
    localparam int KEY_W = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic                 div_q = 1'b0;
    logic                 div_ena;
    logic [ROWS-1:0]      row_n;
    logic [COLS-1:0]      col_n;
    logic                 key_valid;
    logic [KEY_W-1:0]     key_code;
    logic                 key_ready;
    logic                 key_held;
    logic                 key_lost;
    logic [ROWS*COLS-1:0] keys;

    int         checks   = 0;
    int         failures = 0;
    int         rise_cnt = 0;
    int         dcnt     = 0;
    int         lost_cnt = 0;
    int         exp_row  = 0;
    bit         exp_valid = 1'b0;
    logic [3:0] exp_code  = '0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .DEBOUNCE_TICKS (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .div_q     (div_q),
        .div_ena   (div_ena),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .key_held  (key_held),
        .key_lost  (key_lost)
    );

    function automatic logic [COLS-1:0] pad_cols(input logic [ROWS-1:0] rn, input logic [ROWS*COLS-1:0] k);
        logic [COLS-1:0] c;
        c = '1;
        for (int r = 0; r < ROWS; r++)
            for (int cc = 0; cc < COLS; cc++)
                if (rn[r] === 1'b0 && k[r*COLS+cc]) c[cc] = 1'b0;
        return c;
    endfunction

    assign col_n = pad_cols(row_n, keys);

    function automatic logic [ROWS-1:0] rowpat(input int r);
        logic [ROWS-1:0] one;
        one = 1;
        return ~(one << r);
    endfunction

    // Divider model: one rising edge every 10 clk while enabled.
    always @(negedge clk) begin
        if (div_ena !== 1'b1) begin
            dcnt  = 0;
            div_q = 1'b0;
        end else begin
            dcnt = (dcnt == 9) ? 0 : dcnt + 1;
            if (dcnt == 5 && !div_q) rise_cnt++;
            div_q = (dcnt >= 5);
        end
        if (key_lost === 1'b1) lost_cnt++;
    end

    task automatic wait_tick(input string tag);
        int start;
        bit seen;
        start = rise_cnt;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            if (rise_cnt != start) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s tick_timeout: no divider tick in 40 clk, div_ena=%b", tag, div_ena);
        end else begin
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic scan_to_key(input int kr, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2*ROWS && !found; i++) begin
            wait_tick(tag);
            if (exp_row == kr) found = 1'b1;
            else exp_row = (exp_row + 1) % ROWS;
            checks++;
            if (row_n !== rowpat(exp_row)) begin
                failures++;
                $display("FAIL %s scan_row: row_n=%b expected %b", tag, row_n, rowpat(exp_row));
            end
        end
        checks++;
        if (key_held !== 1'b1) begin
            failures++;
            $display("FAIL %s held_on_detect: key_held=%b expected 1", tag, key_held);
        end
    endtask

    task automatic press_key(input int r, input int c, input bit rdy, input string tag);
        bit lost_exp;
        keys = '0;
        keys[r*COLS+c] = 1'b1;
        scan_to_key(r, tag);
        for (int i = 1; i <= DB; i++) begin
            wait_tick(tag);
            checks++;
            if (row_n !== rowpat(r) || key_valid !== exp_valid) begin
                failures++;
                $display("FAIL %s debounce_%0d: row_n=%b key_valid=%b expected row_n=%b key_valid=%b",
                         tag, i, row_n, key_valid, rowpat(r), exp_valid);
            end
        end
        key_ready = rdy;
        @(posedge clk);
        #1;
        key_ready = 1'b0;
        lost_exp = exp_valid && !rdy;
        if (!lost_exp) exp_code = 4'(r*COLS + c);
        exp_valid = 1'b1;
        checks++;
        if (key_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s report_valid: key_valid=%b expected 1", tag, key_valid);
        end
        checks++;
        if (key_code !== exp_code) begin
            failures++;
            $display("FAIL %s report_code: key_code=%0d expected %0d", tag, key_code, exp_code);
        end
        checks++;
        if (key_lost !== lost_exp) begin
            failures++;
            $display("FAIL %s report_lost: key_lost=%b expected %b", tag, key_lost, lost_exp);
        end
        checks++;
        if (key_held !== 1'b1) begin
            failures++;
            $display("FAIL %s report_held: key_held=%b expected 1", tag, key_held);
        end
    endtask

    task automatic release_key(input int r, input string tag);
        keys = '0;
        for (int i = 1; i <= DB; i++) begin
            wait_tick(tag);
            if (i == DB) exp_row = (r + 1) % ROWS;
            checks++;
            if (key_held !== (i < DB) || row_n !== rowpat(exp_row == r ? r : exp_row)) begin
                failures++;
                $display("FAIL %s release_%0d: key_held=%b row_n=%b expected key_held=%b row_n=%b",
                         tag, i, key_held, row_n, (i < DB), rowpat(exp_row));
            end
        end
    endtask

    task automatic consume(input string tag);
        key_ready = 1'b1;
        @(posedge clk);
        #1;
        key_ready = 1'b0;
        exp_valid = 1'b0;
        checks++;
        if (key_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s consume: key_valid=%b expected 0", tag, key_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        key_ready = 1'b0;
        keys = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({row_n, div_ena, key_valid, key_code, key_held, key_lost} !== {4'b1111, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values: row_n=%b div_ena=%b valid=%b code=%0d held=%b lost=%b",
                     row_n, div_ena, key_valid, key_code, key_held, key_lost);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (row_n !== 4'b1111 || div_ena !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: row_n=%b div_ena=%b expected 1111 0", row_n, div_ena);
        end
    endtask

    task automatic test_scan();
        enable = 1'b1;
        @(posedge clk);
        #1;
        exp_row = 0;
        checks++;
        if (row_n !== 4'b1110 || div_ena !== 1'b1) begin
            failures++;
            $display("FAIL scan_start: row_n=%b div_ena=%b expected 1110 1", row_n, div_ena);
        end
        for (int k = 1; k <= 5; k++) begin
            wait_tick("scan");
            exp_row = (exp_row + 1) % ROWS;
            checks++;
            if (row_n !== rowpat(exp_row) || key_valid !== 1'b0 || div_ena !== 1'b1) begin
                failures++;
                $display("FAIL scan_step_%0d: row_n=%b valid=%b div_ena=%b expected %b 0 1",
                         k, row_n, key_valid, div_ena, rowpat(exp_row));
            end
        end
    endtask

    task automatic test_clean_press();
        press_key(2, 1, 1'b0, "clean");
        checks++;
        if (key_code !== 4'd9) begin
            failures++;
            $display("FAIL clean_code9: key_code=%0d expected 9", key_code);
        end
        consume("clean");
        release_key(2, "clean");
        checks++;
        if (row_n !== 4'b0111) begin
            failures++;
            $display("FAIL clean_resume_row3: row_n=%b expected 0111", row_n);
        end
    endtask

    task automatic test_bounce();
        int r;
        int c;
        r = $urandom_range(0, ROWS-1);
        c = $urandom_range(0, COLS-1);
        keys = '0;
        keys[r*COLS+c] = 1'b1;
        scan_to_key(r, "bounce");
        wait_tick("bounce");
        keys = '0;
        wait_tick("bounce");
        checks++;
        if (row_n !== rowpat(r) || key_valid !== 1'b0) begin
            failures++;
            $display("FAIL bounce_back_to_scan: row_n=%b valid=%b expected %b 0", row_n, key_valid, rowpat(r));
        end
        keys[r*COLS+c] = 1'b1;
        wait_tick("bounce");
        checks++;
        if (row_n !== rowpat(r) || key_held !== 1'b1) begin
            failures++;
            $display("FAIL bounce_redetect: row_n=%b held=%b expected %b 1", row_n, key_held, rowpat(r));
        end
        for (int i = 1; i <= DB; i++) begin
            wait_tick("bounce");
            checks++;
            if (key_valid !== 1'b0) begin
                failures++;
                $display("FAIL bounce_early_valid_%0d: key_valid=%b expected 0", i, key_valid);
            end
        end
        @(posedge clk);
        #1;
        exp_valid = 1'b1;
        exp_code  = 4'(r*COLS + c);
        checks++;
        if (key_valid !== 1'b1 || key_code !== exp_code) begin
            failures++;
            $display("FAIL bounce_report: valid=%b code=%0d expected 1 %0d", key_valid, key_code, exp_code);
        end
        consume("bounce");
        release_key(r, "bounce");
    endtask

    task automatic test_two_cols();
        keys = '0;
        keys[0*COLS+1] = 1'b1;
        keys[0*COLS+2] = 1'b1;
        for (int i = 0; i < 2*ROWS; i++) begin
            wait_tick("twocol");
            exp_row = (exp_row + 1) % ROWS;
            checks++;
            if (row_n !== rowpat(exp_row) || key_valid !== 1'b0 || key_held !== 1'b0) begin
                failures++;
                $display("FAIL twocol_step_%0d: row_n=%b valid=%b held=%b expected %b 0 0",
                         i, row_n, key_valid, key_held, rowpat(exp_row));
            end
        end
        keys = '0;
    endtask

    task automatic test_lost();
        int lost_before;
        press_key(1, 1, 1'b0, "lost_k5");
        release_key(1, "lost_k5");
        lost_before = lost_cnt;
        press_key(3, 0, 1'b0, "lost_k12");
        @(posedge clk);
        #1;
        checks++;
        if (key_lost !== 1'b0 || lost_cnt != lost_before + 1) begin
            failures++;
            $display("FAIL lost_single_pulse: key_lost=%b pulses=%0d expected 0 %0d",
                     key_lost, lost_cnt - lost_before, 1);
        end
        release_key(3, "lost_k12");
        checks++;
        if (key_code !== 4'd5 || key_valid !== 1'b1) begin
            failures++;
            $display("FAIL lost_keeps5: code=%0d valid=%b expected 5 1", key_code, key_valid);
        end
        consume("lost");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int r;
            int c;
            bit rdy;
            r = $urandom_range(0, ROWS-1);
            c = $urandom_range(0, COLS-1);
            rdy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) consume("rand");
            press_key(r, c, rdy, "rand");
            release_key(r, "rand");
        end
    endtask

    task automatic test_enable_drop();
        int r;
        r = $urandom_range(0, ROWS-1);
        keys = '0;
        keys[r*COLS] = 1'b1;
        scan_to_key(r, "endrop");
        wait_tick("endrop");
        enable = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (row_n !== 4'b1111 || div_ena !== 1'b0 || key_held !== 1'b0 || key_valid !== exp_valid) begin
            failures++;
            $display("FAIL endrop_idle: row_n=%b div_ena=%b held=%b valid=%b expected 1111 0 0 %b",
                     row_n, div_ena, key_held, key_valid, exp_valid);
        end
        keys = '0;
        enable = 1'b1;
        @(posedge clk);
        #1;
        exp_row = 0;
        checks++;
        if (row_n !== 4'b1110 || div_ena !== 1'b1) begin
            failures++;
            $display("FAIL endrop_restart: row_n=%b div_ena=%b expected 1110 1", row_n, div_ena);
        end
        wait_tick("endrop");
        exp_row = 1;
        checks++;
        if (row_n !== 4'b1101) begin
            failures++;
            $display("FAIL endrop_first_tick: row_n=%b expected 1101", row_n);
        end
    endtask

    task automatic test_async_reset();
        press_key(3, 2, 1'b1, "arst");
        wait_tick("arst");
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({row_n, div_ena, key_valid, key_code, key_held, key_lost} !== {4'b1111, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL arst_values: row_n=%b div_ena=%b valid=%b code=%0d held=%b lost=%b",
                     row_n, div_ena, key_valid, key_code, key_held, key_lost);
        end
        keys = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        key_ready = 1'b0;
        keys = '0;
        test_reset();
        test_scan();
        test_clean_press();
        test_bounce();
        test_two_cols();
        test_lost();
        test_random();
        test_enable_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
